// File: rtl/pulse_chk_pkg.sv
// Shared types and default constants for the strobe generator / period checker pair.
package pulse_chk_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam int DEF_N        = 12500;
   localparam int DEF_CBITS    = 14;
   localparam int DEF_LOCK_CNT = 2;

   // Width needed to hold the good-interval count up to and including lock_cnt.
   function automatic int good_bits(input int lock_cnt);
      return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
   endfunction

endpackage

// File: rtl/pulse_period_checker_if.sv
// Status bundle of the pulse period checker; optional miss counter under PULSE_CHK_STATS_EN.
interface pulse_period_checker_if
   import pulse_chk_pkg::*;
#(
   parameter int CBITS = DEF_CBITS
) ();

   // No valid/ready here: sig is a one-cycle strobe sampled every clk edge, and every
   // status signal is a registered level (early/late are single-cycle pulses) that the
   // consumer samples at any time; locked is the qualifier for trusting the strobe.
   logic             sig;
   logic             locked;
   logic             early;
   logic             late;
   logic             err;
   logic [CBITS-1:0] gap;
   logic [CBITS-1:0] cnt;
   state_t           state;

`ifdef PULSE_CHK_STATS_EN
   logic [15:0]      miss_cnt;

   modport master (output sig, input locked, early, late, err, gap, cnt, state, miss_cnt);
   modport slave  (input sig, output locked, early, late, err, gap, cnt, state, miss_cnt);
`else
   modport master (output sig, input locked, early, late, err, gap, cnt, state);
   modport slave  (input sig, output locked, early, late, err, gap, cnt, state);
`endif

endinterface

// File: rtl/pulse_interval_cnt.sv
// Saturating cycle counter cleared by each pulse; captures the measured interval on the pulse.
module pulse_interval_cnt #(
   parameter int CBITS = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   output logic [CBITS-1:0] cnt,
   output logic [CBITS-1:0] interval,
   output logic [CBITS-1:0] gap
);

   // Saturating increment doubles as the interval that a pulse this cycle would measure.
   always_comb begin
      interval = (&cnt) ? cnt : cnt + CBITS'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         gap <= '0;
      end else if (sig) begin
         cnt <= '0;
         gap <= interval;
      end else begin
         cnt <= interval;
      end
   end

endmodule

// File: rtl/pulse_period_checker.sv
// Locks onto a periodic pulse of period N+1 and flags early/late pulses once locked.
// Optional PULSE_CHK_STATS_EN adds a saturating miss_cnt of early/late events.
module pulse_period_checker
   import pulse_chk_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int CBITS    = DEF_CBITS,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic                   clk,
   input  logic                   rst,
   pulse_period_checker_if.slave  bus
);

   localparam int               GBITS     = good_bits(LOCK_CNT);
   localparam logic [CBITS-1:0] CNT_N     = CBITS'(N);
   localparam logic [CBITS-1:0] CNT_NP1   = CBITS'(N + 1);
   localparam logic [GBITS-1:0] GOOD_LAST = GBITS'(LOCK_CNT - 1);

   logic [CBITS-1:0] cnt;
   logic [CBITS-1:0] interval;
   logic [CBITS-1:0] gap;

   state_t           state_q, state_d;
   logic [GBITS-1:0] good_q, good_d;
   logic             early_d, late_d;
   logic             locked_q, early_q, late_q, err_q;

   pulse_interval_cnt #(.CBITS(CBITS)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .sig      (bus.sig),
      .cnt      (cnt),
      .interval (interval),
      .gap      (gap)
   );

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      early_d = 1'b0;
      late_d  = 1'b0;
      case (state_q)
         HUNT: begin
            if (bus.sig) begin
               state_d = SYNC;
               good_d  = '0;
            end
         end
         SYNC: begin
            if (bus.sig) begin
               if (interval == CNT_NP1) begin
                  good_d = good_q + GBITS'(1);
                  if (good_q == GOOD_LAST) state_d = LOCK;
               end else begin
                  // A wrong interval restarts qualification from this pulse.
                  good_d = '0;
               end
            end else if (cnt == CNT_NP1) begin
               state_d = HUNT;
            end
         end
         LOCK: begin
            if (bus.sig && (cnt < CNT_N)) begin
               early_d = 1'b1;
               state_d = SYNC;
               good_d  = '0;
            end else if (!bus.sig && (cnt == CNT_N)) begin
               late_d  = 1'b1;
               state_d = HUNT;
            end
         end
         default: begin
            state_d = HUNT;
            good_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         good_q   <= '0;
         locked_q <= 1'b0;
         early_q  <= 1'b0;
         late_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         locked_q <= (state_d == LOCK);
         early_q  <= early_d;
         late_q   <= late_d;
         err_q    <= err_q | early_d | late_d;
      end
   end

`ifdef PULSE_CHK_STATS_EN
   logic [15:0] miss_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         miss_q <= '0;
      end else if ((early_d || late_d) && (miss_q != 16'hFFFF)) begin
         miss_q <= miss_q + 16'd1;
      end
   end

   assign bus.miss_cnt = miss_q;
`endif

   assign bus.locked = locked_q;
   assign bus.early  = early_q;
   assign bus.late   = late_q;
   assign bus.err    = err_q;
   assign bus.gap    = gap;
   assign bus.cnt    = cnt;
   assign bus.state  = state_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker (N=10, CBITS=4, LOCK_CNT=2) with an event scoreboard.
module tb_pulse_period_checker;
   import pulse_chk_pkg::*;

   localparam int TN       = 10;
   localparam int TCBITS   = 4;
   localparam int TLOCK    = 2;
   localparam int W        = 32;

   localparam logic [1:0] EV_EARLY  = 2'd0;
   localparam logic [1:0] EV_LATE   = 2'd1;
   localparam logic [1:0] EV_LOCK   = 2'd2;
   localparam logic [1:0] EV_UNLOCK = 2'd3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_locked = 1'b0;

   logic [W-1:0] exp_q[$];

   pulse_period_checker_if #(.CBITS(TCBITS)) bus ();

   pulse_period_checker #(
      .N        (TN),
      .CBITS    (TCBITS),
      .LOCK_CNT (TLOCK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event word: kind, err, gap, edge index at which the outputs change
   function automatic logic [W-1:0] mk_ev(input logic [1:0] kind, input int edge_n,
                                          input logic [3:0] g, input logic e);
      logic [31:0] en;
      en = edge_n;
      return {kind, e, g, 5'd0, en[19:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic check_ev(input logic [1:0] kind);
      logic [W-1:0] act;
      logic [W-1:0] want;
      act = mk_ev(kind, cyc, bus.gap, bus.err);
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL event: got kind=%0d edge=%0d gap=%0d err=%0d, want no event",
                  act[31:30], act[19:0], act[28:25], act[29]);
      end else begin
         want = exp_q.pop_front();
         if (act !== want) begin
            n_err++;
            $display("FAIL event: got kind=%0d edge=%0d gap=%0d err=%0d, want kind=%0d edge=%0d gap=%0d err=%0d",
                     act[31:30], act[19:0], act[28:25], act[29],
                     want[31:30], want[19:0], want[28:25], want[29]);
         end
      end
   endtask

   // monitor: samples on the falling edge, pops one expectation per observed event
   always @(negedge clk) begin
      if (bus.early === 1'b1) check_ev(EV_EARLY);
      if (bus.late === 1'b1) check_ev(EV_LATE);
      if (bus.locked === 1'b1 && prev_locked == 1'b0) check_ev(EV_LOCK);
      if (bus.locked === 1'b0 && prev_locked == 1'b1) check_ev(EV_UNLOCK);
      prev_locked = (bus.locked === 1'b1);
   end

   // driver tasks
   task automatic step(input logic s, input logic r);
      bus.sig = s;
      rst     = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // pulse sampled g edges after the previous pulse
   task automatic send_pulse(input int g);
      idle(g - 1);
      step(1'b1, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      bus.sig = 1'b0;
      repeat (3) step(1'b0, 1'b1);

      chk("rst_locked", bus.locked, 0);
      chk("rst_early", bus.early, 0);
      chk("rst_late", bus.late, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_gap", bus.gap, 0);
      chk("rst_cnt", bus.cnt, 0);
      chk("rst_state", bus.state, HUNT);
`ifdef PULSE_CHK_STATS_EN
      chk("rst_miss_cnt", bus.miss_cnt, 0);
`endif

      // clean train of 11-cycle intervals
      send_pulse(11);
      chk("first_gap", bus.gap, 11);
      chk("first_state", bus.state, SYNC);
      send_pulse(11);
      chk("second_state", bus.state, SYNC);
      exp_q.push_back(mk_ev(EV_LOCK, cyc + 11, 4'd11, 1'b0));
      send_pulse(11);
      send_pulse(11);
      chk("lock_hold", bus.locked, 1);
      chk("lock_err_clean", bus.err, 0);

      // early pulse
      exp_q.push_back(mk_ev(EV_EARLY, cyc + 7, 4'd7, 1'b1));
      exp_q.push_back(mk_ev(EV_UNLOCK, cyc + 7, 4'd7, 1'b1));
      send_pulse(7);
      chk("early_state", bus.state, SYNC);
      chk("early_gap", bus.gap, 7);
      send_pulse(11);
      exp_q.push_back(mk_ev(EV_LOCK, cyc + 11, 4'd11, 1'b1));
      send_pulse(11);
      chk("relock_err_sticky", bus.err, 1);

      // missing pulse
      exp_q.push_back(mk_ev(EV_LATE, cyc + 11, 4'd11, 1'b1));
      exp_q.push_back(mk_ev(EV_UNLOCK, cyc + 11, 4'd11, 1'b1));
      idle(11);
      chk("late_pulse", bus.late, 1);
      chk("late_state", bus.state, HUNT);
      idle(1);
      chk("late_one_cycle", bus.late, 0);
      send_pulse(2);
      chk("after_late_state", bus.state, SYNC);
      chk("after_late_gap", bus.gap, 14);
`ifdef PULSE_CHK_STATS_EN
      chk("miss_cnt_two", bus.miss_cnt, 2);
`endif

      // relock, then reset together with the expected pulse
      send_pulse(11);
      exp_q.push_back(mk_ev(EV_LOCK, cyc + 11, 4'd11, 1'b1));
      send_pulse(11);
      exp_q.push_back(mk_ev(EV_UNLOCK, cyc + 11, 4'd0, 1'b0));
      idle(10);
      step(1'b1, 1'b1);
      chk("rstsig_locked", bus.locked, 0);
      chk("rstsig_err", bus.err, 0);
      chk("rstsig_gap", bus.gap, 0);
      chk("rstsig_cnt", bus.cnt, 0);
      chk("rstsig_state", bus.state, HUNT);
`ifdef PULSE_CHK_STATS_EN
      chk("rstsig_miss_cnt", bus.miss_cnt, 0);
`endif

      // single pulse then silence: counter saturates, back to HUNT
      send_pulse(11);
      chk("sat_first_state", bus.state, SYNC);
      chk("sat_first_gap", bus.gap, 11);
      idle(30);
      chk("sat_cnt", bus.cnt, 15);
      chk("sat_state", bus.state, HUNT);
      chk("sat_err", bus.err, 0);
      step(1'b1, 1'b0);
      chk("sat_gap", bus.gap, 15);
      chk("sat_resync", bus.state, SYNC);
      send_pulse(11);
      exp_q.push_back(mk_ev(EV_LOCK, cyc + 11, 4'd11, 1'b0));
      send_pulse(11);
      chk("final_locked", bus.locked, 1);

      idle(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
